multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port opcode, input, 4 bits: instruction[15:12]; sampled only in DECODE.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag; sampled only in EXEC for BEQ.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes in the cycle it is high while mem_req is high.
REQ-006 SHALL have outputs mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, halted, illegal: each 1 bit, control strobes.
REQ-007 SHALL have outputs pc_src (2 bits: 00 ALU, 01 branch target, 10 jump address), alu_src_b (2 bits: 00 reg, 01 const 1, 10 sign-extended imm[11:6]) and alu_op (2 bits: 00 add, 01 sub, 10 funct-driven, 11 opcode-driven logic).
REQ-008 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-009 SHALL decode opcodes as follows: 0000 R-type; 0001 ADDI; 0010 ANDI; 0011 ORI; 0100 LW; 0101 SW; 0110 BEQ; 0111 J; 1000 JAL; 1001 HALT; 1010-1111 illegal.
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL return to FETCH on the next edge.
REQ-011 In FETCH the block SHALL assert mem_req=1 and iord=0, holding them until mem_ready=1; in the mem_ready cycle it SHALL assert ir_write, pc_write, pc_src=00, alu_src_a=0, alu_src_b=01 and alu_op=00, then go to DECODE.
REQ-012 In DECODE, J SHALL assert pc_write with pc_src=10 and go to FETCH; JAL SHALL additionally assert reg_write (link to R7) in the same cycle; HALT SHALL go to HALT.
REQ-013 In DECODE, an illegal opcode SHALL set the sticky illegal flag and go to FETCH; all other opcodes SHALL go to EXEC.
REQ-014 In EXEC, R-type SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10 and go to WB.
REQ-015 In EXEC, ADDI/LW/SW SHALL drive alu_src_b=10 and alu_op=00; ANDI/ORI SHALL drive alu_src_b=10 and alu_op=11; LW/SW SHALL go to MEM and ADDI/ANDI/ORI to WB.
REQ-016 In EXEC, BEQ SHALL drive alu_op=01 and pc_write=zero with pc_src=01, then go to FETCH.
REQ-017 In MEM the block SHALL assert mem_req=1 and iord=1, with mem_we=1 for SW, holding them until mem_ready; then LW SHALL go to WB and SW to FETCH.
REQ-018 In WB the block SHALL assert reg_write for one cycle, with reg_dst=1 for R-type and 0 otherwise and mem_to_reg=1 only for LW, then go to FETCH.
REQ-019 HALT SHALL be absorbing until reset, with halted=1 and every strobe 0.
REQ-020 All outputs SHALL be Moore/Mealy combinational from state, latched opcode and inputs; the opcode SHALL be registered in DECODE and used in later states.
REQ-021 Minimum cycles per instruction SHALL be: R/I-ALU 4, LW 5, SW 4, BEQ 3, J/JAL 2, each increased by the cycles mem_ready is low.
REQ-022 mem_req SHALL never deassert before mem_ready is seen, and no strobe other than mem_req/iord/mem_we SHALL be asserted while waiting.

Reset
REQ-023 rst=1 SHALL asynchronously force state=FETCH, clear the opcode register, clear illegal and clear halted.
REQ-024 While rst=1 all outputs SHALL be 0; after release, mem_req SHALL assert in the first cycle.
REQ-025 Reset asserted mid-access SHALL abandon the access with no write strobe emitted.

Structure
REQ-026 Package cpu_pkg SHALL hold the state enum, the opcode constants and the pc_src/alu_src_b/alu_op encodings, shared with decoder and datapath.
REQ-027 The combinational output decode SHALL be a sub-module, ctrl_out_decode (inputs: state, opcode, zero, mem_ready); the FSM register stays in the top module.

Verification
REQ-028 Reset, then opcode=0000 with mem_ready tied high -> FETCH,DECODE,EXEC,WB; reg_write=1 with reg_dst=1 exactly in cycle 4.
REQ-029 LW with mem_ready low 2 cycles in MEM -> mem_req=1 and iord=1 held for 3 cycles; WB with mem_to_reg=1; 7 cycles total.
REQ-030 BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 with pc_src=01 in EXEC of the first; pc_write=0 in EXEC of the second.
REQ-031 opcode=1100 -> illegal=1 from cycle 3 onward, next FETCH follows; opcode=1001 -> halted=1 and mem_req stays 0 for 20 cycles.
REQ-032 Assert rst during MEM of SW with mem_ready low -> state=0 immediately, mem_we=0, illegal/halted cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode and control-field encodings for the multicycle CPU.
// Holds the FSM state enum, opcode constants, pc_src/alu_src_b/alu_op codes,
// the bundled control-strobe struct and an illegal-opcode helper.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_R    = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_ANDI = 4'h2;
   localparam logic [3:0] OP_ORI  = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h6;
   localparam logic [3:0] OP_J    = 4'h7;
   localparam logic [3:0] OP_JAL  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'h9;

   localparam logic [1:0] PC_ALU = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LOGIC = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic       halted;
      logic [1:0] pc_src;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   // Opcodes above HALT are unassigned.
   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_HALT;
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational control-strobe decode for the multicycle controller.
// Ports: state (current FSM state), opcode (live opcode in DECODE, latched
// opcode otherwise), zero (ALU zero flag), mem_ready (memory handshake),
// ctrl (bundled control strobes and selects).
module ctrl_out_decode
   import cpu_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req = 1'b1;
            // PC+1 and IR load happen only in the cycle memory delivers.
            if (mem_ready) begin
               ctrl.ir_write  = 1'b1;
               ctrl.pc_write  = 1'b1;
               ctrl.pc_src    = PC_ALU;
               ctrl.alu_src_b = SRCB_ONE;
               ctrl.alu_op    = ALU_ADD;
            end
         end
         S_DECODE: begin
            if (opcode == OP_J || opcode == OP_JAL) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_src    = PC_JMP;
               ctrl.reg_write = (opcode == OP_JAL);
            end
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            case (opcode)
               OP_R:                   ctrl.alu_op = ALU_FUNCT;
               OP_ADDI, OP_LW, OP_SW:  ctrl.alu_src_b = SRCB_IMM;
               OP_ANDI, OP_ORI: begin
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.alu_op    = ALU_LOGIC;
               end
               OP_BEQ: begin
                  ctrl.alu_op   = ALU_SUB;
                  ctrl.pc_src   = PC_BR;
                  ctrl.pc_write = zero;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.mem_we  = (opcode == OP_SW);
         end
         S_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = (opcode == OP_R);
            ctrl.mem_to_reg = (opcode == OP_LW);
         end
         S_HALT:  ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing fetch/decode/exec/mem/writeback for a 16-bit multicycle CPU.
// Ports: clk, rst (async active-high), opcode (instr[15:12]), zero (ALU flag),
// mem_ready (memory handshake); control strobes mem_req, mem_we, iord,
// ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, halted,
// illegal (sticky); selects pc_src, alu_src_b, alu_op; debug state.
module multicycle_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic       halted,
   output logic       illegal,
   output logic [1:0] pc_src,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] state
);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] op_q;
   logic       illegal_q;
   logic [3:0] op_cur;
   ctrl_t      ctl;
   ctrl_t      c;

   // The opcode register only loads at the end of DECODE, so DECODE itself
   // must look at the live instruction bits.
   assign op_cur = (state_q == S_DECODE) ? opcode : op_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (state_q == S_DECODE && is_illegal(opcode)) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_d = (opcode == OP_HALT) ? S_HALT :
                             (opcode == OP_J || opcode == OP_JAL || is_illegal(opcode)) ? S_FETCH : S_EXEC;
         S_EXEC:   state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM :
                             (op_q == OP_BEQ) ? S_FETCH : S_WB;
         S_MEM:    state_d = !mem_ready ? S_MEM : (op_q == OP_LW) ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   ctrl_out_decode u_dec (
      .state     (state_q),
      .opcode    (op_cur),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (ctl)
   );

   // Reset forces FETCH, which would otherwise raise mem_req; gate every
   // strobe so nothing is emitted while rst is held.
   assign c          = rst ? '0 : ctl;
   assign mem_req    = c.mem_req;
   assign mem_we     = c.mem_we;
   assign iord       = c.iord;
   assign ir_write   = c.ir_write;
   assign pc_write   = c.pc_write;
   assign reg_write  = c.reg_write;
   assign reg_dst    = c.reg_dst;
   assign mem_to_reg = c.mem_to_reg;
   assign alu_src_a  = c.alu_src_a;
   assign halted     = c.halted;
   assign pc_src     = c.pc_src;
   assign alu_src_b  = c.alu_src_b;
   assign alu_op     = c.alu_op;
   assign illegal    = illegal_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven, hand-sequenced and randomized checks of multicycle_controller.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst;
   logic       mem_to_reg, alu_src_a, halted, illegal;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;
   logic ill = 1'b0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .halted(halted),
      .illegal(illegal), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .state(state)
   );

   localparam logic [19:0] MREQ = 20'h1 << 19, MWE = 20'h1 << 18, IORD = 20'h1 << 17;
   localparam logic [19:0] IRW = 20'h1 << 16, PCW = 20'h1 << 15, RW = 20'h1 << 14;
   localparam logic [19:0] RDST = 20'h1 << 13, M2R = 20'h1 << 12, ASA = 20'h1 << 11;
   localparam logic [19:0] HLT = 20'h1 << 10, ILL = 20'h1 << 9;
   localparam logic [19:0] PCB = 20'h1 << 7, PCJ = 20'h2 << 7;
   localparam logic [19:0] SB1 = 20'h1 << 5, SBI = 20'h2 << 5;
   localparam logic [19:0] ASUB = 20'h1 << 3, AF = 20'h2 << 3, AL = 20'h3 << 3;
   localparam logic [19:0] S0 = 20'd0, S1 = 20'd1, S2 = 20'd2, S3 = 20'd3, S4 = 20'd4, S5 = 20'd5;
   localparam logic [19:0] ALL = 20'hFFFFF, NASA = ~ASA;

   typedef struct {
      logic        r;
      logic [3:0]  op;
      logic        z;
      logic        mr;
      logic [19:0] e;
      logic [19:0] c;
      string       n;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic [3:0] op, input logic z,
                              input logic mr, input logic [19:0] e, input logic [19:0] c, input string n);
      vec_t x;
      x.r = r; x.op = op; x.z = z; x.mr = mr; x.e = e; x.c = c; x.n = n;
      return x;
   endfunction

   function automatic void chk(input logic [19:0] e, input logic [19:0] c, input string n);
      logic [19:0] got;
      got = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, halted, illegal, pc_src, alu_src_b, alu_op, state};
      n_cmp++;
      if (((got ^ e) & c) != 0) begin
         n_bad++;
         $display("FAIL %s: got %05h expected %05h (care %05h) at %0t", n, got, e, c, $time);
      end
   endfunction

   task automatic step(input logic r, input logic [3:0] op, input logic z, input logic mr,
                       input logic [19:0] e, input logic [19:0] c, input string n);
      rst = r; opcode = op; zero = z; mem_ready = mr;
      @(negedge clk);
      chk(e, c, n);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Instruction-level reference: expected cycle trace from the opcode's class,
   // the number of fetch/memory wait cycles and the zero flag.
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
      logic [19:0] il, e, c;
      logic z;
      il = ill ? ILL : '0;
      for (int i = 0; i < fw; i++) step(0, rop(), rb(), 0, MREQ | il | S0, ALL, "fetch_wait");
      step(0, rop(), rb(), 1, MREQ | IRW | PCW | SB1 | il | S0, ALL, "fetch");
      e = S1 | il;
      if (op == 4'd7) e |= PCW | PCJ;
      if (op == 4'd8) e |= PCW | PCJ | RW;
      step(0, op, rb(), rb(), e, ALL, "decode");
      if (op > 4'd9) begin
         ill = 1'b1;
         return;
      end
      if (op == 4'd7 || op == 4'd8) return;
      if (op == 4'd9) begin
         for (int i = 0; i < 20; i++) step(0, rop(), rb(), rb(), HLT | il | S5, ALL, "halt");
         return;
      end
      z = rb();
      e = S2 | il;
      c = NASA;
      case (op)
         4'd0: begin e |= ASA | AF; c = ALL; end
         4'd1, 4'd4, 4'd5: e |= SBI;
         4'd2, 4'd3: e |= SBI | AL;
         default: e |= ASUB | PCB | (z ? PCW : '0);
      endcase
      step(0, rop(), z, rb(), e, c, "exec");
      if (op == 4'd4 || op == 4'd5) begin
         e = MREQ | IORD | (op == 4'd5 ? MWE : '0) | il | S3;
         for (int i = 0; i < mw; i++) step(0, rop(), rb(), 0, e, ALL, "mem_wait");
         step(0, rop(), rb(), 1, e, ALL, "mem");
      end
      if (op != 4'd5 && op != 4'd6)
         step(0, rop(), rb(), rb(), RW | (op == 4'd0 ? RDST : '0) | (op == 4'd4 ? M2R : '0) | il | S4, ALL, "wb");
   endtask

   initial begin
      logic [3:0] op;
      @(posedge clk);
      #1;
      tbl.push_back(v(1, 4'h0, 0, 1, '0, ALL, "reset"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "r_fetch"));
      tbl.push_back(v(0, 4'h0, 0, 1, S1, ALL, "r_decode"));
      tbl.push_back(v(0, 4'hF, 0, 1, ASA | AF | S2, ALL, "r_exec"));
      tbl.push_back(v(0, 4'h5, 0, 1, RW | RDST | S4, ALL, "r_wb"));
      tbl.push_back(v(0, 4'h3, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "addi_fetch"));
      tbl.push_back(v(0, 4'h1, 0, 1, S1, ALL, "addi_decode"));
      tbl.push_back(v(0, 4'h0, 0, 1, SBI | S2, NASA, "addi_exec"));
      tbl.push_back(v(0, 4'h0, 0, 1, RW | S4, ALL, "addi_wb"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "j_fetch"));
      tbl.push_back(v(0, 4'h7, 0, 1, PCW | PCJ | S1, ALL, "j_decode"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "jal_fetch"));
      tbl.push_back(v(0, 4'h8, 0, 1, PCW | PCJ | RW | S1, ALL, "jal_decode"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "beq1_fetch"));
      tbl.push_back(v(0, 4'h6, 0, 1, S1, ALL, "beq1_decode"));
      tbl.push_back(v(0, 4'h0, 1, 1, ASUB | PCB | PCW | S2, NASA, "beq1_exec"));
      tbl.push_back(v(0, 4'h0, 1, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "beq0_fetch"));
      tbl.push_back(v(0, 4'h6, 1, 1, S1, ALL, "beq0_decode"));
      tbl.push_back(v(0, 4'h0, 0, 1, ASUB | PCB | S2, NASA, "beq0_exec"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IRW | PCW | SB1 | S0, ALL, "sw_fetch"));
      tbl.push_back(v(0, 4'h5, 0, 1, S1, ALL, "sw_decode"));
      tbl.push_back(v(0, 4'h0, 0, 1, SBI | S2, NASA, "sw_exec"));
      tbl.push_back(v(0, 4'h0, 0, 1, MREQ | IORD | MWE | S3, ALL, "sw_mem"));
      foreach (tbl[i]) step(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].e, tbl[i].c, tbl[i].n);

      run_instr(4'd4, 0, 2);
      run_instr(4'hC, 0, 0);
      run_instr(4'd0, 1, 0);
      run_instr(4'd9, 0, 0);
      step(1, 4'h0, 0, 1, '0, ALL, "rst_after_halt");
      ill = 1'b0;
      run_instr(4'd0, 0, 0);

      run_instr(4'hE, 0, 0);
      step(0, rop(), rb(), 1, MREQ | IRW | PCW | SB1 | ILL | S0, ALL, "swr_fetch");
      step(0, 4'd5, rb(), 1, S1 | ILL, ALL, "swr_decode");
      step(0, rop(), rb(), 1, SBI | ILL | S2, NASA, "swr_exec");
      mem_ready = 1'b0;
      #2;
      chk(MREQ | IORD | MWE | ILL | S3, ALL, "swr_mem");
      rst = 1'b1;
      #1;
      chk('0, ALL, "swr_rst_async");
      @(negedge clk);
      chk('0, ALL, "swr_rst_hold");
      @(posedge clk);
      #1;
      ill = 1'b0;

      for (int k = 0; k < 80; k++) begin
         do op = rop(); while (op == 4'd9);
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
